// File: rtl/calc_result_display.sv
// calc_result_display: double-dabble binary-to-BCD (1 bit/cycle) driving a 4-digit multiplexed 7-seg scan.
// Optional NEG_SIGN_EN: two's complement input, '-' drawn just above the highest nonzero digit.
module calc_result_display #(
  parameter int WIDTH       = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic             valid,
  output logic             busy,
  output logic [6:0]       seg,
  output logic [3:0]       an
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int RW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0]   REF_MAX  = RW'(REFRESH_DIV - 1);
  localparam logic [CNTW-1:0] BIT_LAST = CNTW'(WIDTH - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ERR   = 7'h06;
`ifdef NEG_SIGN_EN
  localparam logic [6:0] SEG_MINUS = 7'h3F;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [15:0]      disp_q, disp_d;
  logic             ovf_q, ovf_d;
  logic [RW-1:0]    refresh_q, refresh_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
`ifdef NEG_SIGN_EN
  logic             neg_pend_q, neg_pend_d;
  logic             neg_q, neg_d;
  logic             load_neg;
`endif

  logic [WIDTH-1:0] load_mag;
  logic             load_ovf;
  logic [14:0]      bcd_adj;
  logic [1:0]       hi;
  logic [3:0]       cur;

  always_comb begin
`ifdef NEG_SIGN_EN
    load_neg = value[WIDTH-1];
    load_mag = load_neg ? (~value + 1'b1) : value;
    load_ovf = load_neg ? (32'(load_mag) > 32'd999) : (32'(value) > 32'd9999);
`else
    load_mag = value;
    load_ovf = 32'(value) > 32'd9999;
`endif
  end

  // Thousands nibble never reaches 5 for an in-range value, so it needs no correction.
  always_comb begin
    bcd_adj[14:12] = bcd_q[14:12];
    for (int i = 0; i < 3; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
`ifdef NEG_SIGN_EN
    neg_pend_d = neg_pend_q;
    neg_d      = neg_q;
`endif
    case (state_q)
      S_IDLE: if (valid) begin
        state_d    = S_CONV;
        sh_d       = load_mag;
        bcd_d      = '0;
        cnt_d      = '0;
        ovf_pend_d = load_ovf;
`ifdef NEG_SIGN_EN
        neg_pend_d = load_neg;
`endif
      end
      S_CONV: begin
        {bcd_d, sh_d} = {bcd_adj, sh_q, 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BIT_LAST) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        disp_d  = bcd_q;
        ovf_d   = ovf_pend_q;
`ifdef NEG_SIGN_EN
        neg_d   = neg_pend_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  function automatic logic [6:0] digit_code(input logic [3:0] d);
    case (d)
      4'd0: digit_code = 7'h40;
      4'd1: digit_code = 7'h79;
      4'd2: digit_code = 7'h24;
      4'd3: digit_code = 7'h30;
      4'd4: digit_code = 7'h19;
      4'd5: digit_code = 7'h12;
      4'd6: digit_code = 7'h02;
      4'd7: digit_code = 7'h78;
      4'd8: digit_code = 7'h00;
      4'd9: digit_code = 7'h10;
      default: digit_code = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    hi = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (disp_q[4*i +: 4] != 4'd0) hi = 2'(i);
    end
    cur = disp_q[{idx_q, 2'b00} +: 4];
    if (ovf_q)            seg_d = (idx_q == 2'd0) ? SEG_ERR : SEG_BLANK;
    else if (idx_q <= hi) seg_d = digit_code(cur);
`ifdef NEG_SIGN_EN
    else if (neg_q && idx_q == hi + 2'd1) seg_d = SEG_MINUS;
`endif
    else                  seg_d = SEG_BLANK;
    an_d      = ~(4'b0001 << idx_q);
    refresh_d = (refresh_q == REF_MAX) ? '0 : refresh_q + 1'b1;
    idx_d     = (refresh_q == REF_MAX) ? idx_q + 2'd1 : idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      refresh_q  <= '0;
      idx_q      <= 2'd0;
      seg_q      <= SEG_BLANK;
      an_q       <= 4'hF;
`ifdef NEG_SIGN_EN
      neg_pend_q <= 1'b0;
      neg_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      refresh_q  <= refresh_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
`ifdef NEG_SIGN_EN
      neg_pend_q <= neg_pend_d;
      neg_q      <= neg_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign seg  = seg_q;
  assign an   = an_q;
endmodule

// File: tb/tb_calc_result_display.sv
// Bench for calc_result_display: decimal-arithmetic display model checked every cycle, plus literal digit checks.
module tb_calc_result_display;
  localparam int WIDTH = 14;
  localparam int RDIV  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid = 1'b0;
  logic [WIDTH-1:0] value = '0;
  logic             busy;
  logic [6:0]       seg;
  logic [3:0]       an;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  calc_result_display #(.WIDTH(WIDTH), .REFRESH_DIV(RDIV)) dut (
    .clk(clk), .rst(rst), .value(value), .valid(valid),
    .busy(busy), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] code7(input int d);
    case (d)
      0: code7 = 7'h40; 1: code7 = 7'h79; 2: code7 = 7'h24; 3: code7 = 7'h30;
      4: code7 = 7'h19; 5: code7 = 7'h12; 6: code7 = 7'h02; 7: code7 = 7'h78;
      8: code7 = 7'h00; default: code7 = 7'h10;
    endcase
  endfunction

  // Four segment patterns, digit i at [7*i +: 7], derived from the number's decimal form.
  function automatic logic [27:0] render(input logic [WIDTH-1:0] v);
    int sv, mag, nd, t;
    bit neg, ovf;
    logic [27:0] r;
`ifdef NEG_SIGN_EN
    sv = $signed(v);
    neg = sv < 0;
    mag = neg ? -sv : sv;
    ovf = neg ? (mag > 999) : (mag > 9999);
`else
    sv = int'(v);
    neg = 0;
    mag = sv;
    ovf = mag > 9999;
`endif
    r = {4{7'h7F}};
    if (ovf) begin
      r[6:0] = 7'h06;
      return r;
    end
    nd = 1;
    t = mag / 10;
    while (t > 0) begin nd++; t = t / 10; end
    t = mag;
    for (int i = 0; i < nd; i++) begin
      r[7*i +: 7] = code7(t % 10);
      t = t / 10;
    end
    if (neg && nd < 4) r[7*nd +: 7] = 7'h3F;
    return r;
  endfunction

  logic [27:0]      m_disp;
  logic [6:0]       exp_seg;
  logic [3:0]       exp_an;
  logic             exp_busy;
  int               m_edge, m_commit;
  bit               m_pend;
  logic [WIDTH-1:0] m_val;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edge = 0; m_pend = 0; m_commit = 0; m_val = '0;
      m_disp = render('0);
      exp_seg = 7'h7F; exp_an = 4'hF; exp_busy = 1'b0;
    end else begin
      m_edge++;
      exp_an  = ~(4'b0001 << (((m_edge - 1) / RDIV) % 4));
      exp_seg = m_disp[7*(((m_edge - 1) / RDIV) % 4) +: 7];
      if (m_pend && m_edge == m_commit) begin
        m_disp = render(m_val);
        m_pend = 0;
      end else if (!m_pend && valid) begin
        m_pend = 1;
        m_commit = m_edge + WIDTH + 1;
        m_val = value;
      end
      exp_busy = m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("scan_an", int'(an), int'(exp_an));
      check("scan_seg", int'(seg), int'(exp_seg));
      check("busy", int'(busy), int'(exp_busy));
    end
  end

  task automatic load(input logic [WIDTH-1:0] v);
    @(negedge clk); valid = 1'b1; value = v;
    @(negedge clk); valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic capture(output logic [27:0] got);
    got = '0;
    for (int c = 0; c < 8 * RDIV; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) got[7*i +: 7] = seg;
    end
  endtask

  task automatic expect4(input string name, input logic [27:0] got,
                         input logic [6:0] d3, input logic [6:0] d2,
                         input logic [6:0] d1, input logic [6:0] d0);
    check({name, "_d0"}, int'(got[6:0]),   int'(d0));
    check({name, "_d1"}, int'(got[13:7]),  int'(d1));
    check({name, "_d2"}, int'(got[20:14]), int'(d2));
    check({name, "_d3"}, int'(got[27:21]), int'(d3));
  endtask

  initial begin
    int n;
    logic [27:0] g;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_seg", int'(seg), 'h7F);
    check("rst_an", int'(an), 'hF);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    chk_en = 1;
    @(negedge clk);
    check("first_an", int'(an), 'hE);
    check("first_seg", int'(seg), 'h40);

    load(14'd1234); wait_idle(n);
    check("busy_cycles", n, 15);
    capture(g); expect4("v1234", g, 7'h79, 7'h24, 7'h30, 7'h19);

    load(14'd7); wait_idle(n); capture(g);
    expect4("v7", g, 7'h7F, 7'h7F, 7'h7F, 7'h78);
    load(14'd0); wait_idle(n); capture(g);
    expect4("v0", g, 7'h7F, 7'h7F, 7'h7F, 7'h40);
    load(14'd10000); wait_idle(n); capture(g);
    expect4("v10000", g, 7'h7F, 7'h7F, 7'h7F, 7'h06);
`ifndef NEG_SIGN_EN
    load(14'd9999); wait_idle(n); capture(g);
    expect4("v9999", g, 7'h10, 7'h10, 7'h10, 7'h10);
`endif

    load(14'd321);
    repeat (3) @(negedge clk);
    valid = 1'b1; value = 14'd55;
    @(negedge clk); valid = 1'b0;
    wait_idle(n);
    check("idle_after_pulse", int'(busy), 0);
    capture(g); expect4("v321", g, 7'h7F, 7'h30, 7'h24, 7'h79);

    load(14'd5678);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_seg", int'(seg), 'h7F);
    check("async_rst_an", int'(an), 'hF);
    check("async_rst_busy", int'(busy), 0);
    @(negedge clk); rst = 1'b0;
    capture(g); expect4("after_rst", g, 7'h7F, 7'h7F, 7'h7F, 7'h40);

`ifdef NEG_SIGN_EN
    load(14'(-42)); wait_idle(n); capture(g);
    expect4("vneg42", g, 7'h7F, 7'h3F, 7'h19, 7'h24);
    load(14'(-1000)); wait_idle(n); capture(g);
    expect4("vneg1000", g, 7'h7F, 7'h7F, 7'h7F, 7'h06);
`endif

    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        valid = 1'b1;
        case ($urandom_range(0, 4))
          0: value = 14'($urandom_range(0, 9));
          1: value = 14'($urandom_range(0, 999));
          2: value = 14'($urandom_range(9990, 10010));
          3: value = 14'(-int'($urandom_range(0, 1100)));
          default: value = 14'($urandom_range(0, 16383));
        endcase
      end else if ($urandom_range(0, 1) == 0) begin
        valid = 1'b0;
      end
    end
    valid = 1'b0;
    wait_idle(n);
    check("final_idle", int'(busy), 0);
    @(negedge clk);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
